// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle R-type / I-arith / branch core.
// Drives datapath enables and selects per state, gates issue with run/step, and counts retirements.
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             br_taken,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             result_src,
  output logic             imm_src,
  output logic [3:0]       alu_control,
  output logic             halted,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXECR  = 3'b011,
    S_EXECI  = 3'b100,
    S_ALUWB  = 3'b101,
    S_BRANCH = 3'b110,
    S_HALT   = 3'b111
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t           r_state;
  state_t           w_next;
  logic             r_step_s1;
  logic             r_step_s2;
  logic             r_step_prev;
  logic             r_step_rise;
  logic             w_go;
  logic [CNT_W-1:0] r_count;

  // funct7b5 selects SUB only for register ops; for immediates it is part of the
  // immediate except on the shift-right encoding, where it picks SRAI.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b5,
                                            input logic is_imm);
    logic [3:0] sel;
    sel = ALU_ADD;
    case (f3)
      3'b000:  sel = (b5 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      3'b111:  sel = ALU_AND;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

  // Button path: two-flop synchroniser, edge register, then a registered one-cycle
  // rise pulse, giving four clock edges from button to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_s1   <= 1'b0;
      r_step_s2   <= 1'b0;
      r_step_prev <= 1'b0;
      r_step_rise <= 1'b0;
    end else begin
      r_step_s1   <= step;
      r_step_s2   <= r_step_s1;
      r_step_prev <= r_step_s2;
      r_step_rise <= r_step_s2 & ~r_step_prev;
    end
  end

  // A rise pulse seen outside IDLE is simply lost; run and step together issue once.
  assign w_go = run | r_step_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (r_state == S_ALUWB || r_state == S_BRANCH) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 1'b0;
    imm_src     = 1'b0;
    alu_control = ALU_ADD;
    halted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_next = S_FETCH;
      end
      S_FETCH: begin
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 1'b1;
        pc_write   = 1'b1;
        ir_write   = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        // oldPC + B-immediate precomputes the branch target into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 1'b1;
        case (op)
          OP_R:    w_next = S_EXECR;
          OP_I:    w_next = S_EXECI;
          OP_B:    w_next = S_BRANCH;
          default: w_next = S_HALT;
        endcase
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = alu_decode(funct3, funct7b5, 1'b0);
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        imm_src     = 1'b0;
        alu_control = alu_decode(funct3, funct7b5, 1'b1);
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = 1'b0;
        reg_write  = 1'b1;
        w_next     = S_IDLE;
      end
      S_BRANCH: begin
        // Compare via SUB; PC takes the ALUOut target only when the branch resolves taken.
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = ALU_SUB;
        result_src  = 1'b0;
        pc_write    = br_taken;
        w_next      = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign state_dbg   = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level reference model of the state walk and
// per-state control outputs, with a CNT_W=2 copy sharing the stimulus to observe counter wrap.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       br_taken = 1'b0;

  logic        pc_write, ir_write, reg_write, result_src, imm_src, halted;
  logic [1:0]  alu_src_a, alu_src_b;
  logic [3:0]  alu_control;
  logic [2:0]  state_dbg;
  logic [15:0] instr_count;

  logic        d2_pc_write, d2_ir_write, d2_reg_write, d2_result_src, d2_imm_src, d2_halted;
  logic [1:0]  d2_alu_src_a, d2_alu_src_b;
  logic [3:0]  d2_alu_control;
  logic [2:0]  d2_state_dbg;
  logic [1:0]  d2_instr_count;

  logic [16:0] obs;
  assign obs = {pc_write, ir_write, reg_write, alu_src_a, alu_src_b, result_src, imm_src,
                alu_control, halted, state_dbg};

  multicycle_controller #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .br_taken(br_taken), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
    .halted(halted), .state_dbg(state_dbg), .instr_count(instr_count)
  );

  multicycle_controller #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .run(run), .step(step), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .br_taken(br_taken), .pc_write(d2_pc_write), .ir_write(d2_ir_write),
    .reg_write(d2_reg_write), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
    .result_src(d2_result_src), .imm_src(d2_imm_src), .alu_control(d2_alu_control),
    .halted(d2_halted), .state_dbg(d2_state_dbg), .instr_count(d2_instr_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXECR = 3;
  localparam int P_EXECI = 4, P_ALUWB = 5, P_BRANCH = 6, P_HALT = 7;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_B = 7'b1100011;

  int total = 0;
  int bad = 0;
  int model_count = 0;

  // ALU opcode per funct3 before the funct7b5 alternates (index = funct3)
  logic [3:0] alu_tab [8] = '{4'b0000, 4'b0101, 4'b1000, 4'b1001,
                              4'b0100, 4'b0110, 4'b0011, 4'b0010};

  function automatic logic [3:0] ref_alu(input logic is_imm, input logic [2:0] f3,
                                         input logic b5);
    logic [3:0] r;
    r = alu_tab[f3];
    if (f3 == 3'b101 && b5) r = 4'b0111;
    if (f3 == 3'b000 && b5 && !is_imm) r = 4'b0001;
    return r;
  endfunction

  function automatic logic [16:0] exp_vec(input int ph, input logic bt, input logic [2:0] f3,
                                          input logic b5);
    logic pcw, irw, rw, rs, is, h;
    logic [1:0] sa, sb;
    logic [3:0] alu;
    logic [2:0] code;
    pcw = 0; irw = 0; rw = 0; rs = 0; is = 0; h = 0; sa = 0; sb = 0; alu = 0;
    code = ph[2:0];
    case (ph)
      P_FETCH:  begin pcw = 1; irw = 1; sb = 2'b10; rs = 1; end
      P_DECODE: begin sa = 2'b01; sb = 2'b01; is = 1; end
      P_EXECR:  begin sa = 2'b10; alu = ref_alu(1'b0, f3, b5); end
      P_EXECI:  begin sa = 2'b10; sb = 2'b01; alu = ref_alu(1'b1, f3, b5); end
      P_ALUWB:  rw = 1;
      P_BRANCH: begin sa = 2'b10; alu = 4'b0001; pcw = bt; end
      P_HALT:   h = 1;
      default:  ;
    endcase
    return {pcw, irw, rw, sa, sb, rs, is, alu, h, code};
  endfunction

  // Driver: one instruction under run=1, entered and left at a negedge with the DUT in IDLE.
  task automatic exec_instr(input logic [6:0] o, input logic [2:0] f3, input logic b5,
                            input logic bt, input string name);
    int seq[$];
    logic [16:0] e;
    logic [15:0] ec;
    logic [1:0]  ec2;
    op = o; funct3 = f3; funct7b5 = b5; br_taken = bt; run = 1'b1;
    seq.push_back(P_IDLE); seq.push_back(P_FETCH); seq.push_back(P_DECODE);
    if (o == OP_R) begin seq.push_back(P_EXECR); seq.push_back(P_ALUWB); seq.push_back(P_IDLE); end
    else if (o == OP_I) begin seq.push_back(P_EXECI); seq.push_back(P_ALUWB); seq.push_back(P_IDLE); end
    else if (o == OP_B) begin seq.push_back(P_BRANCH); seq.push_back(P_IDLE); end
    else seq.push_back(P_HALT);
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) @(negedge clk);
      e = exp_vec(seq[k], bt, f3, b5);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s cyc%0d outputs: got %b want %b", name, k, obs, e);
      end
      if (seq[k] == P_ALUWB || seq[k] == P_BRANCH) model_count++;
    end
    ec = model_count[15:0];
    ec2 = model_count[1:0];
    total++;
    if (instr_count !== ec || d2_instr_count !== ec2) begin
      bad++;
      $display("FAIL %s count: got %0d/%0d want %0d/%0d", name, instr_count, d2_instr_count, ec, ec2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== 17'd0) begin bad++; $display("FAIL reset_outputs: got %b want 0", obs); end
    total++;
    if (instr_count !== 16'd0 || d2_instr_count !== 2'd0) begin
      bad++; $display("FAIL reset_count: got %0d/%0d want 0", instr_count, d2_instr_count);
    end
    reset = 1'b1;
    model_count = 0;
    @(negedge clk);
    total++;
    if (state_dbg !== 3'b000) begin bad++; $display("FAIL idle_no_go: got %b want 000", state_dbg); end
  endtask

  task automatic test_rtype();
    exec_instr(OP_R, 3'b000, 1'b1, 1'b0, "sub");
    exec_instr(OP_R, 3'b111, 1'b0, 1'b0, "and");
    exec_instr(OP_R, 3'b101, 1'b1, 1'b0, "sra");
  endtask

  task automatic test_itype();
    exec_instr(OP_I, 3'b000, 1'b1, 1'b0, "addi_b5");
    exec_instr(OP_I, 3'b101, 1'b1, 1'b0, "srai");
    exec_instr(OP_I, 3'b101, 1'b0, 1'b0, "srli");
  endtask

  task automatic test_branch();
    exec_instr(OP_B, 3'b000, 1'b0, 1'b1, "br_taken");
    exec_instr(OP_B, 3'b001, 1'b0, 1'b0, "br_not_taken");
  endtask

  task automatic test_back_to_back();
    logic [6:0] o;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0: o = OP_R;
        1: o = OP_I;
        default: o = OP_B;
      endcase
      exec_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid();
    op = OP_R; funct3 = 3'b100; funct7b5 = 1'b0; run = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (state_dbg !== 3'b011) begin bad++; $display("FAIL mid_reach_execr: got %b want 011", state_dbg); end
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs !== 17'd0 || instr_count !== 16'd0 || d2_instr_count !== 2'd0) begin
      bad++; $display("FAIL mid_reset: got %b cnt %0d want 0 cnt 0", obs, instr_count);
    end
    model_count = 0;
    @(negedge clk);
    reset = 1'b1;
    exec_instr(OP_R, 3'b010, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_step();
    int n;
    int left;
    logic [15:0] ec;
    run = 1'b0; op = OP_R; funct3 = 3'b110; funct7b5 = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      n = 0;
      while (n < 12 && state_dbg !== 3'b001) begin @(negedge clk); n++; end
      total++;
      if (n != 4) begin bad++; $display("FAIL step_latency: got %0d want 4", n); end
      n = 0;
      while (n < 12 && state_dbg !== 3'b000) begin @(negedge clk); n++; end
      total++;
      if (n != 4) begin bad++; $display("FAIL step_instr_len: got %0d want 4", n); end
      model_count++;
      step = 1'b0;
      left = 0;
      repeat (20) begin @(negedge clk); if (state_dbg !== 3'b000) left++; end
      total++;
      if (left != 0) begin bad++; $display("FAIL step_idle_gap: got %0d non-idle want 0", left); end
    end
    ec = model_count[15:0];
    total++;
    if (instr_count !== ec) begin bad++; $display("FAIL step_count: got %0d want %0d", instr_count, ec); end
    // step edge arriving mid-instruction together with run: one issue, late edge dropped
    run = 1'b1; step = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 0;
    while (n < 12 && state_dbg !== 3'b000) begin @(negedge clk); n++; end
    model_count++;
    step = 1'b0;
    left = 0;
    repeat (12) begin @(negedge clk); if (state_dbg !== 3'b000) left++; end
    ec = model_count[15:0];
    total++;
    if (left != 0 || instr_count !== ec) begin
      bad++; $display("FAIL step_dropped: got %0d non-idle cnt %0d want 0 cnt %0d", left, instr_count, ec);
    end
  endtask

  task automatic test_halt_wrap();
    logic [16:0] e;
    logic [15:0] ec;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_count = 0;
    exec_instr(OP_R, 3'b000, 1'b0, 1'b0, "wrap1");
    exec_instr(OP_I, 3'b011, 1'b0, 1'b0, "wrap2");
    exec_instr(OP_B, 3'b000, 1'b0, 1'b1, "wrap3");
    exec_instr(OP_R, 3'b001, 1'b0, 1'b0, "wrap4");
    exec_instr(OP_I, 3'b110, 1'b0, 1'b0, "wrap5");
    total++;
    if (d2_instr_count !== 2'd1) begin bad++; $display("FAIL wrap_count: got %0d want 1", d2_instr_count); end
    exec_instr(7'b0000000, 3'b000, 1'b0, 1'b0, "halt_entry");
    e = exp_vec(P_HALT, 1'b0, 3'b000, 1'b0);
    ec = model_count[15:0];
    for (int n = 0; n < 30; n++) begin
      run = 1'($urandom_range(0, 1));
      step = 1'($urandom_range(0, 1));
      op = 7'($urandom_range(0, 127));
      @(negedge clk);
      total++;
      if (obs !== e || instr_count !== ec) begin
        bad++; $display("FAIL halt_hold: got %b cnt %0d want %b cnt %0d", obs, instr_count, e, ec);
      end
    end
    run = 1'b0; step = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 17'd0) begin bad++; $display("FAIL halt_exit_reset: got %b want 0", obs); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_back_to_back();
    test_reset_mid();
    test_step();
    test_halt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
